// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    // Serialiser states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int   UART_DATA_WIDTH = 8;
    localparam logic UART_STOP_LEVEL = 1'b1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write / serial-status bundle between a byte producer and the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: producer must watch tx_ready; writes while not ready are dropped.
// Ports: tx_data/tx_data_en (producer -> UART), tx_ready/tx_serial/tx_busy/
//        fifo_count/tx_overflow (UART -> producer/line).
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_data_en;
    logic                  tx_ready;
    logic                  tx_serial;
    logic                  tx_busy;
    logic [CNT_W-1:0]      fifo_count;
    logic                  tx_overflow;

    modport master (
        output tx_data, tx_data_en,
        input  tx_ready, tx_serial, tx_busy, fifo_count, tx_overflow
    );

    modport slave (
        input  tx_data, tx_data_en,
        output tx_ready, tx_serial, tx_busy, fifo_count, tx_overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and registered full/empty flags.
// Latency: a push is visible at the head (empty deasserted) one cycle later.
// Backpressure: push while full and pop while empty are ignored.
// Ports: clk, rst (async, active high), push/push_dat, pop/pop_dat (head, combinational
//        from storage), full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    // Pointers are exactly log2(DEPTH) wide, so they wrap without a compare.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        // Flags come from the next count so they are flops, not decode of count_q.
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of bytes serialised LSB-first as 8N1 (optional even parity).
// Latency: byte written in cycle N starts its start bit on the first baud_tick at or after N+1.
// Backpressure: tx_ready low when the FIFO is full; writes then are dropped and latch tx_overflow.
// Ports: clk, rst (async, active high), baud_tick (one-cycle pulse per bit period),
//        bus (slave side of uart_tx_fifo_if: write strobe in, line and status out).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           baud_tick,
    uart_tx_fifo_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  parity_q, parity_d;
    logic                  serial_q, serial_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;

    logic                  fifo_push, fifo_pop;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_cnt;

    // A write while full is dropped even if the serialiser pops in the same cycle.
    assign fifo_push = bus.tx_data_en & ~fifo_full;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (bus.tx_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        serial_d  = serial_q;
        fifo_pop  = 1'b0;
        ovf_d     = ovf_q | (bus.tx_data_en & fifo_full);

        if (baud_tick) begin
            unique case (state_q)
                // STOP behaves like IDLE: a waiting byte starts immediately, giving
                // back-to-back frames with no idle gap.
                IDLE, STOP: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        serial_d = 1'b0;
                        state_d  = START;
                    end else begin
                        serial_d = UART_IDLE_LEVEL;
                        state_d  = IDLE;
                    end
                end
                START: begin
                    serial_d  = shift_q[0];
                    bit_cnt_d = '0;
                    parity_d  = ^shift_q;
                    state_d   = DATA;
                end
                // bit_cnt counts data bits already on the line; the line shows bit
                // bit_cnt while in DATA.
                DATA: begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        if (PARITY_EN != 0) begin
                            serial_d = parity_q;
                            state_d  = PARITY;
                        end else begin
                            serial_d = UART_STOP_LEVEL;
                            state_d  = STOP;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        serial_d  = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                PARITY: begin
                    serial_d = UART_STOP_LEVEL;
                    state_d  = STOP;
                end
                default: begin
                    serial_d = UART_IDLE_LEVEL;
                    state_d  = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            serial_q  <= UART_IDLE_LEVEL;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.tx_serial   = serial_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_ready    = ~fifo_full;
    assign bus.fifo_count  = fifo_cnt;
    assign bus.tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (one instance without parity, one with).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       gen_tick;
    logic       man_tick;
    logic       tick_en;
    int         tick_per;
    int         tick_cnt;
    logic [7:0] wdat;
    logic       wen;
    logic       sel;
    logic       chk_en;
    logic       baud_tick;
    int         checks;
    int         failures;

    assign baud_tick = gen_tick | man_tick;

    uart_tx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) bus0 ();
    uart_tx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) bus1 ();

    assign bus0.tx_data    = wdat;
    assign bus0.tx_data_en = wen & ~sel;
    assign bus1.tx_data    = wdat;
    assign bus1.tx_data_en = wen & sel;

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus0)
    );
    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus1)
    );

    // Outputs of whichever instance is currently under test.
    logic       d_serial, d_busy, d_ready, d_ovf;
    logic [4:0] d_cnt;
    assign d_serial = sel ? bus1.tx_serial   : bus0.tx_serial;
    assign d_busy   = sel ? bus1.tx_busy     : bus0.tx_busy;
    assign d_ready  = sel ? bus1.tx_ready    : bus0.tx_ready;
    assign d_ovf    = sel ? bus1.tx_overflow : bus0.tx_overflow;
    assign d_cnt    = sel ? bus1.fifo_count  : bus0.fifo_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Free-running baud tick generator.
    always @(negedge clk) begin
        if (tick_en) begin
            if (tick_cnt >= tick_per - 1) begin
                tick_cnt = 0;
                gen_tick = 1'b1;
            end else begin
                tick_cnt = tick_cnt + 1;
                gen_tick = 1'b0;
            end
        end else begin
            tick_cnt = 0;
            gen_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted bytes plus the list of line levels of the
    // frame in flight. Each tick advances one level; the tick that ends the stop level
    // starts the next queued frame or returns the line to idle.
    logic [7:0] mq [$];
    bit         mlev [$];
    int         midx;
    bit         mact;
    bit         mline;
    bit         movf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mlev.delete();
            midx  = 0;
            mact  = 1'b0;
            mline = 1'b1;
            movf  = 1'b0;
        end else begin
            bit         full_b;
            logic [7:0] b;
            full_b = (mq.size() == 16);
            if (baud_tick) begin
                if (mact && midx < mlev.size() - 1) begin
                    midx  = midx + 1;
                    mline = mlev[midx];
                end else if (mq.size() != 0) begin
                    b = mq.pop_front();
                    mlev.delete();
                    mlev.push_back(1'b0);
                    for (int i = 0; i < 8; i++) mlev.push_back(b[i]);
                    if (sel) mlev.push_back(^b);
                    mlev.push_back(1'b1);
                    midx  = 0;
                    mline = 1'b0;
                    mact  = 1'b1;
                end else begin
                    mact  = 1'b0;
                    mline = 1'b1;
                end
            end
            if (wen) begin
                if (full_b) movf = 1'b1;
                else        mq.push_back(wdat);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("model", {23'd0, d_serial, d_busy, d_ready, d_ovf, d_cnt},
                  {23'd0, mline, mact, (mq.size() < 16), movf, 5'(mq.size())});
        end
    end

    task automatic do_reset(input logic s);
        @(negedge clk);
        rst = 1'b1; wen = 1'b0; tick_en = 1'b0; man_tick = 1'b0; sel = s;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge following a clock edge that sampled baud_tick=1.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n = n + 1;
        end while (!baud_tick && n < 3000);
        if (!baud_tick) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL tick_wait: no baud_tick within %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic write_seq(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            wen = 1'b1;
            wdat = first + 8'(k);
        end
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic pulse_tick(input logic w, input logic [7:0] d);
        @(negedge clk);
        man_tick = 1'b1; wen = w; wdat = d;
        @(negedge clk);
        man_tick = 1'b0; wen = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((d_busy || d_cnt != 0) && n < 6000) begin
            @(negedge clk);
            n = n + 1;
        end
        check(name, {30'd0, d_busy, (d_cnt != 0)}, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  din;
        logic        par;
        int          per;
        int          len;
        logic [10:0] lv;   // line levels in transmit order, first level in bit 10
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [10:0] got;
        logic [19:0] got20;
        logic [9:0]  fl;
        int          busy_n;
        bit          idle_ok;

        checks = 0; failures = 0;
        rst = 1'b1; wen = 1'b0; wdat = 8'h00; sel = 1'b0; chk_en = 1'b0;
        tick_en = 1'b0; tick_per = 8; tick_cnt = 0; gen_tick = 1'b0; man_tick = 1'b0;

        tbl[0] = '{din: 8'hA5, par: 1'b0, per: 868, len: 10, lv: 11'b01010010110};
        tbl[1] = '{din: 8'h07, par: 1'b1, per: 8,   len: 11, lv: 11'b01110000011};
        tbl[2] = '{din: 8'hA5, par: 1'b1, per: 5,   len: 11, lv: 11'b01010010101};
        tbl[3] = '{din: 8'h3C, par: 1'b0, per: 8,   len: 10, lv: 11'b00011110010};
        tbl[4] = '{din: 8'hFF, par: 1'b1, per: 6,   len: 11, lv: 11'b01111111101};

        // Reset values of both instances.
        repeat (3) @(negedge clk);
        check("reset_dut0", {23'd0, bus0.tx_serial, bus0.tx_busy, bus0.tx_ready, bus0.tx_overflow, bus0.fifo_count},
              {23'd0, 9'b1_0_1_0_00000});
        check("reset_dut1", {23'd0, bus1.tx_serial, bus1.tx_busy, bus1.tx_ready, bus1.tx_overflow, bus1.fifo_count},
              {23'd0, 9'b1_0_1_0_00000});
        rst = 1'b0;
        chk_en = 1'b1;

        // Single-frame vectors.
        for (int v = 0; v < 5; v++) begin
            do_reset(tbl[v].par);
            tick_per = tbl[v].per;
            tick_en = 1'b1;
            wait_tick();
            write_seq(tbl[v].din, 1);
            got = '0;
            busy_n = 0;
            for (int i = 0; i < tbl[v].len; i++) begin
                wait_tick();
                got[10 - i] = d_serial;
                if (d_busy) busy_n = busy_n + 1;
            end
            wait_tick();
            if (d_busy) busy_n = busy_n + 1;
            check("frame_bits", {21'd0, got}, {21'd0, tbl[v].lv});
            check("busy_ticks", busy_n, tbl[v].len);
            check("frame_end", {26'd0, d_serial, d_cnt}, {26'd0, 1'b1, 5'd0});
        end

        // 0x00 then 0xFF in consecutive cycles: 20 contiguous levels.
        do_reset(1'b0);
        tick_per = 8;
        tick_en = 1'b1;
        wait_tick();
        @(negedge clk); wen = 1'b1; wdat = 8'h00;
        @(negedge clk); wdat = 8'hFF;
        @(negedge clk); wen = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            wait_tick();
            got20[19 - i] = d_serial;
            if (d_busy) busy_n = busy_n + 1;
        end
        check("b2b_bits", {12'd0, got20}, {12'd0, 20'b00000000010111111111});
        check("b2b_busy", busy_n, 20);

        // 17 writes with no ticks: 16 kept, one dropped, then drained in order.
        do_reset(1'b0);
        write_seq(8'h00, 17);
        check("overflow_fill", {26'd0, d_ready, d_ovf, d_cnt}, {26'd0, 1'b0, 1'b1, 5'd16});
        tick_per = 4;
        tick_en = 1'b1;
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 10; i++) begin
                wait_tick();
                fl[i] = d_serial;
            end
            check("overflow_order", {22'd0, fl}, {22'd0, 1'b1, 8'(f), 1'b0});
        end
        wait_drain("overflow_drain");

        // Full FIFO, write coincident with the pop at the end of a stop bit.
        do_reset(1'b0);
        write_seq(8'h11, 1);
        pulse_tick(1'b0, 8'h00);
        write_seq(8'h20, 16);
        check("full_before_pop", {26'd0, d_ready, d_ovf, d_cnt}, {26'd0, 1'b0, 1'b0, 5'd16});
        for (int i = 0; i < 9; i++) pulse_tick(1'b0, 8'h00);
        pulse_tick(1'b1, 8'h99);
        check("full_coincident", {23'd0, d_serial, d_busy, d_ready, d_ovf, d_cnt},
              {23'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd15});
        tick_per = 4;
        tick_en = 1'b1;
        wait_drain("coincident_drain");

        // Reset during bit 3 of 0x3C with two bytes queued.
        do_reset(1'b0);
        tick_per = 8;
        tick_en = 1'b1;
        wait_tick();
        @(negedge clk); wen = 1'b1; wdat = 8'h3C;
        @(negedge clk); wdat = 8'hAA;
        @(negedge clk); wdat = 8'h55;
        @(negedge clk); wen = 1'b0;
        for (int i = 0; i < 5; i++) wait_tick();
        check("bit3_level", {26'd0, d_serial, d_cnt}, {26'd0, 1'b1, 5'd2});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset", {23'd0, d_serial, d_busy, d_ready, d_ovf, d_cnt},
              {23'd0, 9'b1_0_1_0_00000});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (d_serial !== 1'b1 || d_busy !== 1'b0) idle_ok = 1'b0;
        end
        check("post_reset_idle", {31'd0, idle_ok}, 32'd1);

        // Randomized traffic on both instances against the model.
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            tick_per = $urandom_range(3, 12);
            tick_en = 1'b1;
            for (int c = 0; c < 2500; c++) begin
                @(negedge clk);
                wen  = (c < 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
                wdat = 8'($urandom);
            end
            @(negedge clk);
            wen = 1'b0;
            wait_drain("random_drain");
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter that sits directly downstream of the command-response stage. It accepts bytes on the `tx_data`/`tx_data_en` strobe, queues them in an internal FIFO, and serialises them LSB-first as 8N1 frames, with optional even parity, on `tx_serial`. Bit timing comes from the shared `baud_tick` pulse produced by `baud_tick_gen`.

## Interface
- `DATA_WIDTH`, default 8: bits per character.
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of two, ≥2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between the last data bit and the stop bit.
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `baud_tick` in 1: one-cycle pulse per bit period.
- `tx_data` in DATA_WIDTH: byte to send.
- `tx_data_en` in 1: write strobe; one byte is accepted per high cycle.
- `tx_ready` out 1: FIFO not full.
- `tx_serial` out 1: serial line; idles high.
- `tx_busy` out 1: high whenever the FSM is not in IDLE.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `tx_overflow` out 1: sticky; set by a write while full; cleared only by `rst`.

## Operation
- All outputs are registered. Reset values:
  - `tx_serial`=1, `tx_busy`=0, `tx_ready`=1, `fifo_count`=0, `tx_overflow`=0.
  - FIFO pointers = 0; FSM = IDLE.
- Write path:
  - `tx_data_en` && !full pushes `tx_data`.
  - `tx_data_en` && full drops the byte and sets `tx_overflow`. This applies even if a pop occurs in the same cycle.
- FSM states are IDLE, START, DATA, PARITY, STOP. They advance only on cycles where `baud_tick`=1.
  - IDLE: if the FIFO is non-empty, pop the head into `shift_reg`, set `tx_serial`←0, go to START. Otherwise hold `tx_serial`=1.
  - START: `tx_serial`←`shift_reg[0]`, `bit_cnt`←0, `parity`←^`shift_reg`, go to DATA.
  - DATA: if `bit_cnt`==DATA_WIDTH-1, go to PARITY (`tx_serial`←`parity`) when PARITY_EN, else to STOP (`tx_serial`←1). Otherwise shift right, `tx_serial`←next bit, `bit_cnt`++.
  - PARITY: `tx_serial`←1, go to STOP.
  - STOP: if the FIFO is non-empty, pop, `tx_serial`←0, go to START (back-to-back, no idle gap). Otherwise `tx_serial`←1, go to IDLE.
- Simultaneous push and pop with the FIFO not full: `fifo_count` is unchanged and both take effect.
- Pointer arithmetic: `$clog2(FIFO_DEPTH)`-bit pointers wrap naturally; full/empty are derived from `fifo_count`.

## Timing
- Every line level lasts exactly one baud period. Levels change on the clock edge that samples `baud_tick`=1.
- Frame length is 10 ticks (8N1), or 11 ticks with PARITY_EN.
- Write-to-start-bit latency: a byte written in cycle N is visible to the FSM at N+1. The start bit is driven on the first `baud_tick` at or after N+1.
- `tx_busy` rises with the start bit. It falls on the tick that ends the stop bit when the FIFO is empty.
- `tx_ready` deasserts the cycle after the write that fills the FIFO. It reasserts the cycle after the first pop.
- Asserting `rst` mid-frame forces `tx_serial`=1 immediately (asynchronously) and empties the FIFO. No partial frame resumes after reset.
- `baud_tick` high for multiple consecutive cycles is illegal input and need not be handled.

## Structure
- Package `uart_pkg` holds:
  - `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_WIDTH`=8;
  - `UART_STOP_LEVEL`=1'b1 and `UART_IDLE_LEVEL`=1'b1.
- One sub-module: `sync_fifo`, parameterised on width and depth, with push/pop/full/empty/count outputs and asynchronous active-high reset.
- The top level contains the serialiser FSM, the overflow flag and the output registers.

## Test plan
- Write 0xA5, ticks every 868 clks → `tx_serial` reads 0,1,0,1,0,0,1,0,1,1. `tx_busy` is high for exactly 10 ticks; `fifo_count` returns to 0.
- Write 0x00 then 0xFF in consecutive cycles → 20 contiguous bit periods with no idle level between the first stop bit and the second start bit.
- PARITY_EN=1, write 0x07 → parity bit 1, frame length 11 ticks. Write 0xA5 → parity bit 0.
- With no ticks, write 17 bytes 0x00..0x10 → `fifo_count`=16, `tx_ready`=0, `tx_overflow`=1. Only 0x00..0x0F are transmitted, in order.
- FIFO full, push coincident with a STOP-state pop → push dropped, `tx_overflow`=1, `fifo_count`=15.
- Assert `rst` during bit 3 of 0x3C with 2 bytes queued → `tx_serial`=1 and `fifo_count`=0 within the same cycle. After release, the line stays idle until a new write.
